// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential sram-like fetches, keeps up to DEPTH in flight,
// and hands {pc, inst} to decode in order; a redirect flushes and discards in-flight returns.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_S = (CW + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    alloc_q, alloc_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [CW-1:0]    filled_cnt_s, pending_s;
  logic [CW:0]      inflight_s;
  logic             accept_s, pop_s, ret_keep_s, ret_drop_s;
  logic             unused_s;

  assign unused_s = ^redirect_pc[1:0];

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0000_0000;
  assign inst_addr  = fetch_pc_q;

  // Requests already in flight toward the bridge count against the slot budget,
  // including those that will be discarded after a redirect.
  assign inflight_s = {1'b0, count_q} + {1'b0, drop_q};
  assign inst_req   = resetn && !redirect_valid && (inflight_s < DEPTH_S);
  assign accept_s   = inst_req && inst_addr_ok;

  assign out_valid = filled_q[head_q] && !redirect_valid;
  assign out_pc    = pc_q[head_q];
  assign out_inst  = inst_q[head_q];
  assign pop_s     = out_valid && out_ready;

  assign ret_drop_s = inst_data_ok && (drop_q != '0);
  assign ret_keep_s = inst_data_ok && (drop_q == '0) && !redirect_valid;

  always_comb begin
    filled_cnt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt_s = filled_cnt_s + CW'(filled_q[i]);
    end
  end

  assign pending_s = count_q - filled_cnt_s;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    count_d    = count_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    if (redirect_valid) begin
      // Everything allocated but unfilled is still owed by the bridge and must be swallowed.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_d     = fill_q;
      alloc_d    = fill_q;
      count_d    = '0;
      filled_d   = '0;
      drop_d     = drop_q + pending_s - CW'(inst_data_ok);
    end else begin
      fetch_pc_d       = accept_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
      alloc_d          = accept_s ? (alloc_q + PW'(1)) : alloc_q;
      drop_d           = ret_drop_s ? (drop_q - CW'(1)) : drop_q;
      fill_d           = ret_keep_s ? (fill_q + PW'(1)) : fill_q;
      head_d           = pop_s ? (head_q + PW'(1)) : head_q;
      filled_d[fill_q] = filled_q[fill_q] | ret_keep_s;
      filled_d[head_q] = filled_d[head_q] & ~pop_s;
      count_d          = count_q + CW'(accept_s) - CW'(pop_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= 32'h0000_0000;
        inst_q[i] <= 32'h0000_0000;
      end
    end else begin
      if (accept_s) begin
        pc_q[alloc_q] <= fetch_pc_q;
      end
      if (ret_keep_s) begin
        inst_q[fill_q] <= inst_rdata;
      end
    end
  end

endmodule
